// File: rtl/led_bar_monitor_pkg.sv
// Shared encodings for the LED bar monitor: motion states and sticky error bit positions.
package led_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RISE = 2'd1,
    ST_FALL = 2'd2
  } mon_state_e;

  localparam int ERR_THERM = 0;
  localparam int ERR_STEP  = 1;
  localparam int ERR_STALL = 2;

endpackage

// File: rtl/led_bar_monitor_if.sv
// Observed LED bus plus the decoded monitor results; slave is the monitor side.
interface led_bar_monitor_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  localparam int LW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] led;
  logic             err_clr;
  logic [LW-1:0]    level;
  logic [1:0]       state;
  logic             ext_vld;
  logic             ext_is_peak;
  logic [LW-1:0]    ext_lvl;
  logic             cycle_done;
  logic [CNT_W-1:0] cycle_cnt;
  logic [2:0]       err;

  modport master (
    output led, err_clr,
    input  level, state, ext_vld, ext_is_peak, ext_lvl, cycle_done, cycle_cnt, err
  );

  modport slave (
    input  led, err_clr,
    output level, state, ext_vld, ext_is_peak, ext_lvl, cycle_done, cycle_cnt, err
  );
endinterface

// File: rtl/led_bar_monitor_therm_decode.sv
// Combinational thermometer decoder: valid when led is 2^n-1, count is n.
module therm_decode #(
  parameter  int WIDTH = 16,
  localparam int LW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] led_i,
  output logic             valid_o,
  output logic [LW-1:0]    count_o
);

  logic [WIDTH-1:0] led_inc;

  // A thermometer code plus one is a single bit with no overlap.
  assign led_inc = led_i + {{(WIDTH-1){1'b0}}, 1'b1};
  assign valid_o = ((led_i & led_inc) == '0);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + LW'(led_i[i]);
    end
  end

endmodule

// File: rtl/led_bar_monitor.sv
// Passive observer of the bound_flasher LED bus: tracks level and direction, flags protocol errors.
module led_bar_monitor
  import led_mon_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int STEP_MAX  = 1,
  parameter int STALL_MAX = 8,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  led_bar_monitor_if.slave   mon
);

  localparam int LW = $clog2(WIDTH + 1);
  localparam int SW = $clog2(STALL_MAX + 1);

  logic             therm_valid;
  logic [LW-1:0]    n_lvl;
  logic [LW-1:0]    level_q;
  mon_state_e       state_q;
  logic             ext_vld_q;
  logic             ext_is_peak_q;
  logic [LW-1:0]    ext_lvl_q;
  logic             cycle_done_q;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [2:0]       err_q;
  logic [SW-1:0]    stall_q;
  logic             full_seen_q;

  logic             up;
  logic             down;
  logic [LW-1:0]    delta;
  logic             step_big;

  therm_decode #(.WIDTH(WIDTH)) u_decode (
    .led_i   (mon.led),
    .valid_o (therm_valid),
    .count_o (n_lvl)
  );

  assign up       = (n_lvl > level_q);
  assign down     = (n_lvl < level_q);
  assign delta    = up ? (n_lvl - level_q) : (level_q - n_lvl);
  assign step_big = (int'(delta) > STEP_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q       <= '0;
      state_q       <= ST_IDLE;
      ext_vld_q     <= 1'b0;
      ext_is_peak_q <= 1'b0;
      ext_lvl_q     <= '0;
      cycle_done_q  <= 1'b0;
      cycle_cnt_q   <= '0;
      err_q         <= '0;
      stall_q       <= '0;
      full_seen_q   <= 1'b0;
    end else begin
      ext_vld_q    <= 1'b0;
      cycle_done_q <= 1'b0;
      // Clear first; any bit set below in the same cycle overrides it.
      if (mon.err_clr) err_q <= '0;

      if (!therm_valid) begin
        err_q[ERR_THERM] <= 1'b1;
      end else begin
        level_q <= n_lvl;
        if (step_big) err_q[ERR_STEP] <= 1'b1;

        if (up) begin
          if (state_q == ST_FALL && level_q != '0) begin
            ext_vld_q     <= 1'b1;
            ext_is_peak_q <= 1'b0;
            ext_lvl_q     <= level_q;
          end
          state_q <= ST_RISE;
          stall_q <= '0;
        end else if (down) begin
          if (state_q == ST_RISE) begin
            ext_vld_q     <= 1'b1;
            ext_is_peak_q <= 1'b1;
            ext_lvl_q     <= level_q;
          end
          state_q <= ST_FALL;
          stall_q <= '0;
        end else if (state_q != ST_IDLE) begin
          if (stall_q != SW'(STALL_MAX)) stall_q <= stall_q + SW'(1);
          if (stall_q >= SW'(STALL_MAX - 1)) err_q[ERR_STALL] <= 1'b1;
        end

        if (n_lvl == '0) state_q <= ST_IDLE;
        if (n_lvl == LW'(WIDTH)) full_seen_q <= 1'b1;

        // Back at empty after having been full closes one flasher cycle.
        if (n_lvl == '0 && full_seen_q) begin
          cycle_done_q <= 1'b1;
          full_seen_q  <= 1'b0;
          if (cycle_cnt_q != '1) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign mon.level       = level_q;
  assign mon.state       = state_q;
  assign mon.ext_vld     = ext_vld_q;
  assign mon.ext_is_peak = ext_is_peak_q;
  assign mon.ext_lvl     = ext_lvl_q;
  assign mon.cycle_done  = cycle_done_q;
  assign mon.cycle_cnt   = cycle_cnt_q;
  assign mon.err         = err_q;

endmodule

// File: tb/tb_led_bar_monitor.sv
// Directed bench for led_bar_monitor: ramps, turning points, error flags and async reset.
module tb_led_bar_monitor;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  led_bar_monitor_if #(.WIDTH(16), .CNT_W(8)) mon ();

  led_bar_monitor #(
    .WIDTH(16), .STEP_MAX(1), .STALL_MAX(8), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (mon)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] therm(input int n);
    return 16'((32'd1 << n) - 32'd1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [15:0] v, input logic clr = 1'b0);
    mon.led     = v;
    mon.err_clr = clr;
    @(posedge clk);
    #1;
    mon.err_clr = 1'b0;
    $display("t=%0t led=%04h clr=%0b -> level=%0d state=%0d ext=%0b/%0b/%0d done=%0b cnt=%0d err=%03b",
             $time, v, clr, mon.level, mon.state, mon.ext_vld, mon.ext_is_peak,
             mon.ext_lvl, mon.cycle_done, mon.cycle_cnt, mon.err);
  endtask

  task automatic expect_core(input string tag, input int lvl, input int st,
                             input logic ev, input logic cd, input logic [2:0] e);
    chk($sformatf("%s level", tag), 32'(mon.level), 32'(lvl));
    chk($sformatf("%s state", tag), 32'(mon.state), 32'(st));
    chk($sformatf("%s ext_vld", tag), 32'(mon.ext_vld), 32'(ev));
    chk($sformatf("%s cycle_done", tag), 32'(mon.cycle_done), 32'(cd));
    chk($sformatf("%s err", tag), 32'(mon.err), 32'(e));
  endtask

  task automatic expect_ext(input string tag, input logic pk, input int lvl);
    chk($sformatf("%s is_peak", tag), 32'(mon.ext_is_peak), 32'(pk));
    chk($sformatf("%s ext_lvl", tag), 32'(mon.ext_lvl), 32'(lvl));
  endtask

  initial begin
    rst_n       = 1'b0;
    mon.led     = '0;
    mon.err_clr = 1'b0;
    #12;
    expect_core("reset", 0, 0, 1'b0, 1'b0, 3'b000);
    chk("reset cnt", 32'(mon.cycle_cnt), 32'd0);
    rst_n = 1'b1;

    // 1: small ramp 0..6..0
    step(therm(0));
    expect_core("t1 start", 0, 0, 1'b0, 1'b0, 3'b000);
    for (int i = 1; i <= 6; i++) begin
      step(therm(i));
      expect_core($sformatf("t1 up%0d", i), i, 1, 1'b0, 1'b0, 3'b000);
    end
    for (int i = 5; i >= 0; i--) begin
      step(therm(i));
      expect_core($sformatf("t1 dn%0d", i), i, (i == 0) ? 0 : 2, (i == 5), 1'b0, 3'b000);
      if (i == 5) expect_ext("t1 peak", 1'b1, 6);
    end

    // 2: two full ramps
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= 16; i++) begin
        step(therm(i));
        expect_core($sformatf("t2 r%0d up%0d", r, i), i, 1, 1'b0, 1'b0, 3'b000);
      end
      for (int i = 15; i >= 0; i--) begin
        step(therm(i));
        expect_core($sformatf("t2 r%0d dn%0d", r, i), i, (i == 0) ? 0 : 2,
                    (i == 15), (i == 0), 3'b000);
        if (i == 15) expect_ext("t2 peak", 1'b1, 16);
      end
      chk($sformatf("t2 r%0d cnt", r), 32'(mon.cycle_cnt), 32'(r + 1));
    end

    // 3: peak at 10, valley at 5, end rising at 8
    for (int i = 1; i <= 10; i++) step(therm(i));
    chk("t3 top level", 32'(mon.level), 32'd10);
    for (int i = 9; i >= 5; i--) begin
      step(therm(i));
      if (i == 9) begin
        expect_core("t3 peak", 9, 2, 1'b1, 1'b0, 3'b000);
        expect_ext("t3 peak", 1'b1, 10);
      end
    end
    for (int i = 6; i <= 8; i++) begin
      step(therm(i));
      if (i == 6) begin
        expect_core("t3 valley", 6, 1, 1'b1, 1'b0, 3'b000);
        expect_ext("t3 valley", 1'b0, 5);
      end
    end
    expect_core("t3 end", 8, 1, 1'b0, 1'b0, 3'b000);
    for (int i = 7; i >= 0; i--) step(therm(i));
    expect_core("t3 idle", 0, 0, 1'b0, 1'b0, 3'b000);
    chk("t3 cnt", 32'(mon.cycle_cnt), 32'd2);

    // 4: non-thermometer sample, then clear together with a jump
    step(therm(1));
    step(therm(2));
    step(16'h0005);
    expect_core("t4 bad", 2, 1, 1'b0, 1'b0, 3'b001);
    step(16'h00FF, 1'b1);
    expect_core("t4 jump", 8, 1, 1'b0, 1'b0, 3'b010);
    step(16'h00FF, 1'b1);
    expect_core("t4 clr", 8, 1, 1'b0, 1'b0, 3'b000);
    for (int i = 7; i >= 0; i--) step(therm(i));
    expect_core("t4 idle", 0, 0, 1'b0, 1'b0, 3'b000);

    // 5: stall at level 3, no stall while idle
    for (int i = 1; i <= 3; i++) step(therm(i));
    for (int k = 1; k <= 8; k++) begin
      step(therm(3));
      chk($sformatf("t5 hold%0d err", k), 32'(mon.err), (k == 8) ? 32'h4 : 32'h0);
    end
    step(therm(2), 1'b1);
    expect_core("t5 clr", 2, 2, 1'b1, 1'b0, 3'b000);
    step(therm(1));
    step(therm(0));
    for (int k = 1; k <= 20; k++) step(therm(0));
    expect_core("t5 idle hold", 0, 0, 1'b0, 1'b0, 3'b000);

    // 6: asynchronous reset mid-ramp
    for (int i = 1; i <= 9; i++) step(therm(i));
    chk("t6 pre level", 32'(mon.level), 32'd9);
    #3;
    rst_n = 1'b0;
    #1;
    expect_core("t6 async", 0, 0, 1'b0, 1'b0, 3'b000);
    chk("t6 async cnt", 32'(mon.cycle_cnt), 32'd0);
    mon.led = '0;
    #2;
    rst_n = 1'b1;
    step(therm(0));
    expect_core("t6 resume0", 0, 0, 1'b0, 1'b0, 3'b000);
    for (int i = 1; i <= 3; i++) begin
      step(therm(i));
      expect_core($sformatf("t6 resume%0d", i), i, 1, 1'b0, 1'b0, 3'b000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
